branch_predictor_btb: RTL and testbench

Parametrised branch target buffer with 2-bit saturating direction counters for the pipelined MIPS core. It lets the core predict taken branches and jumps at fetch instead of resolving them in ID and squashing the fetched slot. The fetch stage performs a combinational lookup on the current PC. The ID stage writes resolved outcomes back through a single update port. Saturating statistics counters expose update and mispredict totals to the testbench.

---
 rtl/branch_predictor_btb_if.sv | 30 +++
 rtl/branch_predictor_btb.sv | 99 +++++++++
 tb/tb_branch_predictor_btb.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_btb_if.sv
// Fetch-lookup / ID-update bus between the core and the branch target buffer.
interface branch_predictor_btb_if #(
  parameter int ADDR_W = 32,
  parameter int STAT_W = 32
);
  logic [ADDR_W-1:0] lookup_pc;
  logic              pred_hit;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;

  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_mispredict;
  logic              flush;

  logic [STAT_W-1:0] stat_updates;
  logic [STAT_W-1:0] stat_mispredicts;

  modport master (
    output lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, flush,
    input  pred_hit, pred_taken, pred_target, stat_updates, stat_mispredicts
  );

  modport slave (
    input  lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, flush,
    output pred_hit, pred_taken, pred_target, stat_updates, stat_mispredicts
  );
endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational from registered state (no update bypass); updates,
// flush and statistics take effect on the rising edge of clk.
module branch_predictor_btb #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16,
  parameter int STAT_W  = 32
) (
  input logic                  clk,
  input logic                  rst,
  branch_predictor_btb_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic              entry_valid  [ENTRIES];
  logic [TAG_W-1:0]  entry_tag    [ENTRIES];
  logic [ADDR_W-1:0] entry_target [ENTRIES];
  logic [1:0]        entry_ctr    [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;

  logic [STAT_W-1:0] stat_updates_q;
  logic [STAT_W-1:0] stat_mispredicts_q;

  // Byte-offset bits of the PCs never participate in index or tag.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.lookup_pc[1:0], bus.upd_pc[1:0]};

  assign lk_idx = bus.lookup_pc[IDX_W+1:2];
  assign lk_tag = bus.lookup_pc[ADDR_W-1:IDX_W+2];
  assign up_idx = bus.upd_pc[IDX_W+1:2];
  assign up_tag = bus.upd_pc[ADDR_W-1:IDX_W+2];

  // Fetch-side prediction; not-taken and misses fall through to pc + 4.
  always_comb begin
    lk_hit          = entry_valid[lk_idx] && (entry_tag[lk_idx] == lk_tag);
    bus.pred_hit    = lk_hit;
    bus.pred_taken  = lk_hit && entry_ctr[lk_idx][1];
    bus.pred_target = bus.pred_taken ? entry_target[lk_idx]
                                     : bus.lookup_pc + ADDR_W'(4);
  end

  // Hit detection for the resolved instruction on the update port.
  always_comb begin
    up_hit = entry_valid[up_idx] && (entry_tag[up_idx] == up_tag);
  end

  // Table state: flush wins over a same-cycle update, which is then dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entry_valid[i]  <= 1'b0;
        entry_tag[i]    <= '0;
        entry_target[i] <= '0;
        entry_ctr[i]    <= 2'b01;
      end
    end else if (bus.flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entry_valid[i] <= 1'b0;
      end
    end else if (bus.upd_valid) begin
      if (up_hit) begin
        if (bus.upd_taken) begin
          if (entry_ctr[up_idx] != 2'b11) entry_ctr[up_idx] <= entry_ctr[up_idx] + 2'd1;
          entry_target[up_idx] <= bus.upd_target;
        end else begin
          if (entry_ctr[up_idx] != 2'b00) entry_ctr[up_idx] <= entry_ctr[up_idx] - 2'd1;
        end
      end else if (bus.upd_taken) begin
        // Allocation overwrites whatever aliased into this slot.
        entry_valid[up_idx]  <= 1'b1;
        entry_tag[up_idx]    <= up_tag;
        entry_target[up_idx] <= bus.upd_target;
        entry_ctr[up_idx]    <= 2'b10;
      end
    end
  end

  // Saturating statistics; these keep counting through a flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_updates_q     <= '0;
      stat_mispredicts_q <= '0;
    end else if (bus.upd_valid) begin
      if (stat_updates_q != '1) stat_updates_q <= stat_updates_q + STAT_W'(1);
      if (bus.upd_mispredict && (stat_mispredicts_q != '1))
        stat_mispredicts_q <= stat_mispredicts_q + STAT_W'(1);
    end
  end

  assign bus.stat_updates     = stat_updates_q;
  assign bus.stat_mispredicts = stat_mispredicts_q;
endmodule

// File: tb/tb_branch_predictor_btb.sv
// Self-checking bench for branch_predictor_btb: directed scenarios followed by
// randomized traffic, all compared against a behavioural table model.
module tb_branch_predictor_btb;
  localparam int ADDR_W   = 32;
  localparam int ENTRIES  = 16;
  localparam int STAT_W   = 4;
  localparam int STAT_MAX = (1 << STAT_W) - 1;
  localparam int LINE_SH  = 2 + $clog2(ENTRIES);

  logic clk = 1'b0;
  logic rst = 1'b1;

  branch_predictor_btb_if #(.ADDR_W(ADDR_W), .STAT_W(STAT_W)) bus ();

  branch_predictor_btb #(.ADDR_W(ADDR_W), .ENTRIES(ENTRIES), .STAT_W(STAT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: each slot remembers the full PC that owns it.
  bit          m_valid [ENTRIES];
  logic [31:0] m_pc    [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  int          m_upd;
  int          m_mis;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int slot_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic bit same_tag(input logic [31:0] a, input logic [31:0] b);
    return (a >> LINE_SH) == (b >> LINE_SH);
  endfunction

  task automatic model_reset;
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_pc[i]    = '0;
      m_tgt[i]   = '0;
      m_ctr[i]   = 1;
    end
    m_upd = 0;
    m_mis = 0;
  endtask

  task automatic model_update(input bit uv, input logic [31:0] upc, input bit ut,
                              input logic [31:0] utgt, input bit um, input bit fl);
    int  i;
    bit  hit;
    if (uv) begin
      m_upd = (m_upd + 1 > STAT_MAX) ? STAT_MAX : m_upd + 1;
      if (um) m_mis = (m_mis + 1 > STAT_MAX) ? STAT_MAX : m_mis + 1;
    end
    if (fl) begin
      for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
    end else if (uv) begin
      i   = slot_of(upc);
      hit = m_valid[i] && same_tag(m_pc[i], upc);
      if (hit && ut) begin
        m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
        m_tgt[i] = utgt;
      end else if (hit) begin
        m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
      end else if (ut) begin
        m_valid[i] = 1'b1;
        m_pc[i]    = upc;
        m_tgt[i]   = utgt;
        m_ctr[i]   = 2;
      end
    end
  endtask

  task automatic check_lookup(input string tag);
    logic [31:0] pc;
    int          i;
    bit          hit;
    bit          taken;
    logic [31:0] tgt;
    pc    = bus.lookup_pc;
    i     = slot_of(pc);
    hit   = m_valid[i] && same_tag(m_pc[i], pc);
    taken = hit && (m_ctr[i] >= 2);
    tgt   = taken ? m_tgt[i] : pc + 32'd4;
    check_eq({tag, "_hit"},   {31'd0, bus.pred_hit},   {31'd0, hit});
    check_eq({tag, "_taken"}, {31'd0, bus.pred_taken}, {31'd0, taken});
    check_eq({tag, "_tgt"},   bus.pred_target, tgt);
    check_eq({tag, "_supd"},  {28'd0, bus.stat_updates},     m_upd);
    check_eq({tag, "_smis"},  {28'd0, bus.stat_mispredicts}, m_mis);
  endtask

  // Apply the previous cycle's inputs to the model at the rising edge.
  task automatic commit;
    @(posedge clk);
    if (!rst)
      model_update(bus.upd_valid, bus.upd_pc, bus.upd_taken, bus.upd_target,
                   bus.upd_mispredict, bus.flush);
  endtask

  task automatic cycle(input logic [31:0] lpc, input bit uv, input logic [31:0] upc,
                       input bit ut, input logic [31:0] utgt, input bit um,
                       input bit fl, input string tag);
    commit();
    @(negedge clk);
    rst                = 1'b0;
    bus.lookup_pc      = lpc;
    bus.upd_valid      = uv;
    bus.upd_pc         = upc;
    bus.upd_taken      = ut;
    bus.upd_target     = utgt;
    bus.upd_mispredict = um;
    bus.flush          = fl;
    #1;
    check_lookup(tag);
  endtask

  // Reset is raised mid-cycle with a live update on the bus, which must be lost.
  task automatic do_reset(input logic [31:0] lpc, input string tag);
    commit();
    @(negedge clk);
    rst                = 1'b1;
    bus.lookup_pc      = lpc;
    bus.upd_valid      = 1'b1;
    bus.upd_pc         = lpc;
    bus.upd_taken      = 1'b1;
    bus.upd_target     = $urandom;
    bus.upd_mispredict = 1'b1;
    bus.flush          = 1'b0;
    #1;
    model_reset();
    check_lookup(tag);
  endtask

  localparam logic [31:0] PC_A = 32'h0040_0010;
  localparam logic [31:0] PC_B = 32'h0040_0050;
  localparam logic [31:0] PC_C = 32'h0040_0020;
  localparam logic [31:0] T_A  = 32'h0040_0100;
  localparam logic [31:0] T_B  = 32'h0040_0200;

  initial begin
    logic [31:0] lpc, upc, utgt;
    bus.lookup_pc      = PC_A;
    bus.upd_valid      = 1'b0;
    bus.upd_pc         = '0;
    bus.upd_taken      = 1'b0;
    bus.upd_target     = '0;
    bus.upd_mispredict = 1'b0;
    bus.flush          = 1'b0;
    model_reset();

    do_reset(PC_A, "reset");
    check_eq("reset_tgt_const", bus.pred_target, 32'h0040_0014);
    check_eq("reset_hit_const", {31'd0, bus.pred_hit}, 32'd0);

    cycle(PC_A, 1, PC_A, 1, T_A, 0, 0, "alloc");
    check_eq("alloc_same_cycle_miss", {31'd0, bus.pred_hit}, 32'd0);
    cycle(PC_A, 1, PC_A, 0, 32'h0, 0, 0, "alloc_vis");
    check_eq("alloc_vis_tgt", bus.pred_target, T_A);
    cycle(PC_A, 1, PC_A, 0, 32'h0, 0, 0, "hyst_nt1");
    cycle(PC_A, 1, PC_A, 1, T_A, 0, 0, "hyst_nt2");
    check_eq("hyst_nt_taken0", {31'd0, bus.pred_taken}, 32'd0);
    check_eq("hyst_nt_hit1",   {31'd0, bus.pred_hit},   32'd1);
    cycle(PC_A, 1, PC_A, 1, T_A, 0, 0, "hyst_t1");
    cycle(PC_A, 1, PC_A, 1, T_A, 0, 0, "hyst_t2");
    cycle(PC_A, 1, PC_A, 1, T_A, 0, 0, "hyst_t3");
    cycle(PC_A, 1, PC_A, 0, 32'h0, 0, 0, "hyst_sat");
    cycle(PC_A, 0, PC_A, 0, 32'h0, 0, 0, "hyst_after_nt");
    check_eq("hyst_sat_taken1", {31'd0, bus.pred_taken}, 32'd1);

    cycle(PC_A, 1, PC_B, 1, T_B, 0, 0, "alias_upd");
    cycle(PC_A, 0, PC_A, 0, 32'h0, 0, 0, "alias_a");
    check_eq("alias_a_miss", {31'd0, bus.pred_hit}, 32'd0);
    cycle(PC_B, 0, PC_A, 0, 32'h0, 0, 0, "alias_b");
    check_eq("alias_b_tgt", bus.pred_target, T_B);

    cycle(PC_A, 1, PC_A, 1, T_A, 0, 0, "flush_prep");
    cycle(PC_A, 1, PC_C, 1, T_B, 0, 1, "flush");
    check_eq("flush_prep_hit", {31'd0, bus.pred_hit}, 32'd1);
    cycle(PC_A, 0, PC_A, 0, 32'h0, 0, 0, "flush_a");
    check_eq("flush_a_miss", {31'd0, bus.pred_hit}, 32'd0);
    check_eq("flush_stat_upd", {28'd0, bus.stat_updates}, 32'd11);
    cycle(PC_C, 0, PC_A, 0, 32'h0, 0, 0, "flush_c");
    check_eq("flush_c_miss", {31'd0, bus.pred_hit}, 32'd0);

    cycle(32'hFFFF_FFFC, 0, PC_A, 0, 32'h0, 0, 0, "wrap");
    check_eq("wrap_tgt", bus.pred_target, 32'h0000_0000);

    do_reset(PC_A, "sat_reset");
    for (int n = 0; n < 20; n++)
      cycle(PC_A, 1, {24'h004000, 8'($urandom)}, 0, 32'h0, 1, 0, "sat_run");
    cycle(PC_A, 0, PC_A, 0, 32'h0, 0, 0, "sat_end");
    check_eq("sat_upd_15", {28'd0, bus.stat_updates},     32'd15);
    check_eq("sat_mis_15", {28'd0, bus.stat_mispredicts}, 32'd15);
    do_reset(PC_A, "sat_clear");
    check_eq("sat_clear_upd", {28'd0, bus.stat_updates},     32'd0);
    check_eq("sat_clear_mis", {28'd0, bus.stat_mispredicts}, 32'd0);

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset({24'h004000, 8'($urandom)}, "rnd_reset");
      end else begin
        lpc  = ($urandom_range(0, 9) == 0) ? $urandom : {24'h004000, 8'($urandom)};
        upc  = {24'h004000, 8'($urandom)};
        utgt = $urandom;
        cycle(lpc, $urandom_range(0, 2) != 0, upc, $urandom_range(0, 2) != 0, utgt,
              $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0, "rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
